// File: rtl/uart_tx.sv
// uart_tx: oversampled UART transmitter, LSB first, optional odd parity bit.
// Bit timing follows the shared tick_16x strobe; the request handshake runs at clk rate.
`timescale 1ns/1ps
module uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int OVS_FACTOR = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick_16x,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_enable,
  output logic                 tx_ready,
  output logic                 tx_pin,
  output logic                 tx_done
);
  localparam int OVS_W = (OVS_FACTOR > 1) ? $clog2(OVS_FACTOR) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [OVS_W-1:0] OVS_LAST = OVS_W'(OVS_FACTOR - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  generate
    if (OVS_FACTOR < 2 || (OVS_FACTOR & (OVS_FACTOR - 1)) != 0) begin : g_bad_ovs
      $fatal(1, "uart_tx: OVS_FACTOR (%0d) must be a power of 2", OVS_FACTOR);
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
      $fatal(1, "uart_tx: DATA_BITS (%0d) must be in 5..8", DATA_BITS);
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state_reg;
  logic [OVS_W-1:0]     os_count_reg;
  logic [IDX_W-1:0]     bit_index_reg;
  logic [IDX_W-1:0]     bit_index_next;
  logic [DATA_BITS-1:0] data_reg;
  logic                 parity_en_reg;
  logic                 bit_end;

  // os_count wraps naturally at OVS_FACTOR because the factor is a power of 2
  assign bit_end        = tick_16x && (os_count_reg == OVS_LAST);
  assign bit_index_next = bit_index_reg + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      os_count_reg  <= '0;
      bit_index_reg <= '0;
      data_reg      <= '0;
      parity_en_reg <= 1'b0;
      tx_pin        <= 1'b1;
      tx_ready      <= 1'b1;
      tx_done       <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state_reg != IDLE && tick_16x) begin
        os_count_reg <= os_count_reg + OVS_W'(1);
      end
      case (state_reg)
        IDLE: begin
          tx_pin   <= 1'b1;
          tx_ready <= 1'b1;
          if (tx_valid && tx_ready) begin
            data_reg      <= tx_data;
            parity_en_reg <= parity_enable;
            os_count_reg  <= '0;
            bit_index_reg <= '0;
            state_reg     <= START;
            tx_pin        <= 1'b0;
            tx_ready      <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_reg <= DATA;
            tx_pin    <= data_reg[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_index_reg == IDX_LAST) begin
              if (parity_en_reg) begin
                state_reg <= PARITY;
                tx_pin    <= ~^data_reg;
              end else begin
                state_reg <= STOP;
                tx_pin    <= 1'b1;
              end
            end else begin
              bit_index_reg <= bit_index_next;
              tx_pin        <= data_reg[bit_index_next];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_reg <= STOP;
            tx_pin    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_reg <= IDLE;
            tx_pin    <= 1'b1;
            tx_ready  <= 1'b1;
            tx_done   <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          os_count_reg  <= '0;
          bit_index_reg <= '0;
          tx_pin        <= 1'b1;
          tx_ready      <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench; expected frames are queued at request time and a
// line-level receiver model decodes tx_pin, popping and comparing each frame.
`timescale 1ns/1ps
module tb_uart_tx;
  localparam int OVS = 16;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_16x = 1'b0;
  logic       tx_valid = 1'b0;
  logic       parity_enable = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx_pin;
  logic       tx_done;

  uart_tx #(.DATA_BITS(8), .OVS_FACTOR(OVS)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick_16x      (tick_16x),
    .tx_valid      (tx_valid),
    .tx_data       (tx_data),
    .parity_enable (parity_enable),
    .tx_ready      (tx_ready),
    .tx_pin        (tx_pin),
    .tx_done       (tx_done)
  );

  always #5 clk = ~clk;

  int     n_checks = 0;
  int     n_fail = 0;
  int     n_sent = 0;
  frame_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic void expect_frame(input logic [7:0] d, input logic p);
    exp_q.push_back('{data: d, par: p});
    n_sent++;
  endfunction

  // Oversample strobe: one pulse every tick_div clocks, changed on the falling edge
  int tick_div = 4;
  bit tick_en = 1'b1;
  int tick_phase = 0;
  initial begin
    forever begin
      @(negedge clk);
      tick_phase = (tick_phase + 1 >= tick_div) ? 0 : tick_phase + 1;
      tick_16x = tick_en && (tick_phase == 0);
    end
  end

  int done_cycles = 0;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (tx_done === 1'b1) done_cycles++;
    end
  end

  // Receiver model state
  bit mon_busy = 1'b0;
  bit mon_abort = 1'b0;
  bit mon_timeout = 1'b0;
  int mon_glitch = 0;
  int mon_ready_bad = 0;
  int mon_early_done = 0;
  int mon_frames = 0;

  task automatic mon_bit(input logic cur);
    int ticks = 0;
    int cyc = 0;
    while (ticks < OVS && !mon_abort && !mon_timeout) begin
      @(posedge clk); #1;
      cyc++;
      if (reset === 1'b1) begin
        mon_abort = 1'b1;
      end else begin
        if (tick_16x === 1'b1) ticks++;
        if (ticks < OVS) begin
          if (tx_pin !== cur) mon_glitch++;
          if (tx_ready !== 1'b0) mon_ready_bad++;
          if (tx_done !== 1'b0) mon_early_done++;
        end
        if (cyc > 400) mon_timeout = 1'b1;
      end
    end
  endtask

  initial begin
    frame_t     e;
    logic [7:0] d;
    logic       p;
    logic       stop_v;
    forever begin
      @(posedge clk); #1;
      if (reset === 1'b0 && tx_pin === 1'b0) begin
        mon_busy = 1'b1;
        check("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = '0;
        mon_abort = 1'b0;
        mon_timeout = 1'b0;
        mon_glitch = 0;
        mon_ready_bad = 0;
        mon_early_done = 0;
        d = '0;
        p = 1'b0;
        mon_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
          d[i] = tx_pin;
          mon_bit(d[i]);
        end
        if (e.par) begin
          p = tx_pin;
          mon_bit(p);
        end
        stop_v = tx_pin;
        mon_bit(1'b1);
        if (!mon_abort) begin
          mon_frames++;
          check("bit_timeout", mon_timeout, 0);
          check("data", d, e.data);
          if (e.par) check("parity", p, ~^e.data);
          check("stop_bit", stop_v, 1);
          check("bit_glitch", mon_glitch, 0);
          check("ready_in_frame", mon_ready_bad, 0);
          check("done_early", mon_early_done, 0);
          check("done_at_stop_end", tx_done, 1);
          check("ready_at_stop_end", tx_ready, 1);
          check("pin_at_stop_end", tx_pin, 1);
          $display("frame %0d: sent %02h par_en=%0b received %02h par=%0b", mon_frames, e.data, e.par, d, p);
        end else begin
          $display("frame %02h aborted by reset", e.data);
        end
        mon_busy = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic p);
    int c = 0;
    int lat = 0;
    while (tx_ready !== 1'b1 && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    tx_data = d;
    parity_enable = p;
    tx_valid = 1'b1;
    expect_frame(d, p);
    do begin
      @(posedge clk); #1;
      lat++;
    end while (tx_ready !== 1'b0 && lat < 5000);
    check("accept_latency", lat, 1);
    // Scramble inputs so a frame that fails to latch shows up as bad data
    tx_valid = 1'b0;
    tx_data = 8'($urandom);
    parity_enable = 1'($urandom);
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((mon_busy || exp_q.size() != 0 || tx_ready !== 1'b1) && c < 20000) begin
      @(posedge clk); #1;
      c++;
    end
    check("idle_reached", c < 20000, 1);
  endtask

  initial begin
    int   c;
    int   changes;
    logic pin_ref;

    reset = 1'b1;
    #1;
    check("rst_pin_async", tx_pin, 1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pin", tx_pin, 1);
    check("rst_ready", tx_ready, 1);
    check("rst_done", tx_done, 0);
    reset = 1'b0;

    send(8'h55, 1'b0);
    wait_idle();

    send(8'hA5, 1'b1);
    repeat (100) @(posedge clk);
    #1;
    tick_en = 1'b0;
    @(posedge clk); #1;
    pin_ref = tx_pin;
    changes = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (tx_pin !== pin_ref || tx_ready !== 1'b0 || tx_done !== 1'b0) changes++;
    end
    check("freeze_hold", changes, 0);
    tick_en = 1'b1;
    wait_idle();

    send(8'h07, 1'b1);
    wait_idle();

    // Back-to-back with tx_valid held high
    tx_data = 8'h01;
    parity_enable = 1'b0;
    tx_valid = 1'b1;
    expect_frame(8'h01, 1'b0);
    c = 0;
    do begin
      @(posedge clk); #1;
      c++;
    end while (tx_ready !== 1'b0 && c < 5000);
    check("b2b_first_accept", c, 1);
    tx_data = 8'h80;
    expect_frame(8'h80, 1'b0);
    c = 0;
    while (tx_done !== 1'b1 && c < 5000) begin
      @(posedge clk); #1;
      c++;
    end
    check("b2b_first_done", tx_done, 1);
    @(posedge clk); #1;
    check("b2b_gap_start", tx_pin, 0);
    check("b2b_gap_ready", tx_ready, 0);
    tx_valid = 1'b0;
    wait_idle();

    // Request while busy must be ignored
    send(8'h00, 1'b0);
    repeat (150) @(posedge clk);
    #1;
    check("busy_ready_low", tx_ready, 0);
    tx_data = 8'hFF;
    parity_enable = 1'b1;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
    wait_idle();
    repeat (200) @(posedge clk);
    #1;
    check("no_extra_frame", mon_busy, 0);

    // Reset in data bit 3 (a 0 bit for 0xC3) must raise the line at once
    send(8'hC3, 1'b0);
    repeat (280) @(posedge clk);
    @(negedge clk);
    check("pre_reset_pin", tx_pin, 0);
    #2 reset = 1'b1;
    #1;
    check("reset_pin_async", tx_pin, 1);
    check("reset_ready_async", tx_ready, 1);
    check("reset_done_async", tx_done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(8'h3C, 1'b1);
    wait_idle();

    tick_div = 1;
    for (int i = 0; i < 96; i++) begin
      send(8'($urandom_range(0, 255)), 1'(i % 2));
    end
    wait_idle();

    check("queue_empty", exp_q.size(), 0);
    check("frames_received", mon_frames, n_sent - 1);
    check("done_pulses", done_cycles, n_sent - 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by 2 ms, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter DATA_BITS, default 8: payload bits per frame; legal range 5..8.
REQ-002 Parameter OVS_FACTOR, default 16: tick_16x pulses per bit period; must be a power of 2, otherwise elaboration fails with $fatal.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 tick_16x  input  1  one-clk-wide oversample strobe, shared with uart_rx.
REQ-006 tx_valid  input  1  tx_data is valid, transmit request.
REQ-007 tx_data  input  DATA_BITS  payload byte.
REQ-008 parity_enable  input  1  insert odd-parity bit.
REQ-009 tx_ready  output  1  block is idle and accepts a request this cycle.
REQ-010 tx_pin  output  1  serial line, registered, idle-high.
REQ-011 tx_done  output  1  one-clk pulse at completion of the stop bit.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY, STOP; any illegal encoding returns to IDLE.
REQ-013 Handshake: accept occurs on the clk edge where tx_valid && tx_ready, independent of tick_16x.
REQ-014 On accept: tx_data and parity_enable latched; state->START; os_count->0; bit_index->0; tx_pin->0 on the same edge; tx_ready->0.
REQ-015 tx_valid while tx_ready=0 ignored; tx_data/parity_enable changes after accept do not affect the frame in flight.
REQ-016 os_count advances only on clk edges with tick_16x=1; each bit holds exactly OVS_FACTOR ticks; the bit ends on the tick where os_count==OVS_FACTOR-1 (os_count wraps to 0).
REQ-017 START end -> DATA, tx_pin = data[0].
REQ-018 DATA: LSB first; at each bit end, bit_index+1 and tx_pin = data[bit_index+1]; at end of bit DATA_BITS-1 -> PARITY if latched parity_enable, else STOP.
REQ-019 PARITY: tx_pin = ~^data, making the total count of ones in data+parity odd; bit end -> STOP.
REQ-020 STOP: tx_pin = 1 for one bit period; at bit end -> IDLE, tx_done=1 for exactly that one clk, tx_ready=1 on the same edge.
REQ-021 Frame length: (DATA_BITS+2) x OVS_FACTOR ticks, +OVS_FACTOR with parity (160 / 176 ticks at defaults).
REQ-022 Back-to-back: with tx_valid held high, next accept occurs on the clk edge after tx_ready rises; gap of exactly one clk of tx_pin=1 beyond the stop bit.
REQ-023 tick_16x held low: all outputs and state frozen (except accept in IDLE).
REQ-024 IDLE: tx_pin=1, tx_ready=1, tx_done=0.

Reset
REQ-025 reset asserted forces, without waiting for clk: state IDLE, tx_pin=1, tx_ready=1, tx_done=0, os_count=0, bit_index=0, data register 0.
REQ-026 Reset mid-frame aborts the frame; tx_pin returns high immediately; no tx_done pulse is produced for the aborted frame.
REQ-027 First accept possible on the first clk edge after reset deasserts.

Verification
REQ-028 0x55, parity off, tick every 4 clks -> tx_pin 0,1,0,1,0,1,0,1,0,1, each 16 ticks; tx_done one pulse after 160 ticks.
REQ-029 0xA5, parity on -> data bits 1,0,1,0,0,1,0,1 then parity bit 1, then stop; 176 ticks total; 0x07 parity on -> parity bit 0.
REQ-030 tx_valid held high with 0x01 then 0x80 -> two contiguous frames, second start bit one clk after first tx_done; tx_ready low throughout each frame.
REQ-031 tx_valid pulsed mid-frame with 0xFF -> ignored; in-flight frame unchanged; no extra frame.
REQ-032 reset asserted during bit 3 of DATA -> tx_pin=1 asynchronously, tx_ready=1, no tx_done; a following 0x3C frame is transmitted correctly.
REQ-033 Loopback of tx_pin into uart_rx, 256 random bytes x parity on/off -> every byte received intact; parity_err=0, frame_err=0.
